// File: rtl/res_st_unit_if.sv
// Reservation station shared types and handshake bundle.
// Ports: write bus, CDB broadcast, issue valid/ready, flush, status.
package res_st_pkg;
  localparam int RES_ST_ADDR_WIDTH = 3;
  localparam int RES_ST_OP_WIDTH = 4;
  localparam int ROB_ADDR_WIDTH = 4;

  typedef logic [RES_ST_ADDR_WIDTH-1:0] res_st_addr_t;
  typedef logic [ROB_ADDR_WIDTH-1:0] rob_addr_t;

  typedef struct packed {
    logic [RES_ST_OP_WIDTH-1:0] op;
    res_st_addr_t qj;
    res_st_addr_t qk;
    logic [31:0] vj;
    logic [31:0] vk;
    rob_addr_t rob_addr;
    logic [31:0] a;
    logic busy;
  } res_st_cell_t;
endpackage

interface res_st_unit_if import res_st_pkg::*; ();
  logic res_st_wr_en_in;
  res_st_addr_t res_st_wr_addr_in;
  res_st_cell_t res_st_data_in;
  logic cdb_valid_in;
  res_st_addr_t cdb_tag_in;
  logic [31:0] cdb_data_in;
  logic issue_ready_in;
  logic issue_valid_out;
  logic [RES_ST_OP_WIDTH-1:0] issue_op_out;
  logic [31:0] issue_vj_out;
  logic [31:0] issue_vk_out;
  logic [31:0] issue_a_out;
  rob_addr_t issue_rob_addr_out;
  res_st_addr_t issue_tag_out;
  logic flush_in;
  logic full_out;
  logic [RES_ST_ADDR_WIDTH:0] count_out;
  logic wr_err_out;

  modport master (
    output res_st_wr_en_in, res_st_wr_addr_in, res_st_data_in,
    output cdb_valid_in, cdb_tag_in, cdb_data_in,
    output issue_ready_in, flush_in,
    input issue_valid_out, issue_op_out, issue_vj_out, issue_vk_out,
    input issue_a_out, issue_rob_addr_out, issue_tag_out,
    input full_out, count_out, wr_err_out
  );

  modport slave (
    input res_st_wr_en_in, res_st_wr_addr_in, res_st_data_in,
    input cdb_valid_in, cdb_tag_in, cdb_data_in,
    input issue_ready_in, flush_in,
    output issue_valid_out, issue_op_out, issue_vj_out, issue_vk_out,
    output issue_a_out, issue_rob_addr_out, issue_tag_out,
    output full_out, count_out, wr_err_out
  );
endinterface

// File: rtl/res_st_unit.sv
// Reservation station: entry writes, CDB wakeup, fixed-priority issue.
// Ports: clk, rst (async high), bus (res_st_unit_if.slave).
module res_st_unit import res_st_pkg::*; #(
  parameter int RES_ST_DEPTH = 2 ** RES_ST_ADDR_WIDTH
) (
  input logic clk,
  input logic rst,
  res_st_unit_if.slave bus
);
  localparam int D = RES_ST_DEPTH;

  res_st_cell_t ent [D];
  logic [D-1:0] iss;
  logic [D-1:0] busy_v;

  logic iv;
  logic [RES_ST_OP_WIDTH-1:0] iop;
  logic [31:0] ivj, ivk, ia;
  rob_addr_t irob;
  res_st_addr_t itag;
  logic err;

  logic hs, load, acc, sel_ok;
  res_st_addr_t sel;
  res_st_cell_t wcell;
  logic [RES_ST_ADDR_WIDTH:0] cnt;

  always_comb begin
    for (int i = 0; i < D; i++) busy_v[i] = ent[i].busy;
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < D; i++)
      cnt += (RES_ST_ADDR_WIDTH+1)'(busy_v[i]);
  end

  // Descending scan so the lowest eligible index wins.
  always_comb begin
    sel_ok = 1'b0;
    sel = '0;
    for (int i = D - 1; i >= 1; i--) begin
      if (ent[i].busy && ent[i].qj == '0 &&
          ent[i].qk == '0 && !iss[i]) begin
        sel_ok = 1'b1;
        sel = RES_ST_ADDR_WIDTH'(i);
      end
    end
  end

  assign hs = iv && bus.issue_ready_in;
  assign load = !iv || hs;
  assign acc = bus.res_st_wr_en_in &&
               bus.res_st_wr_addr_in != '0 &&
               int'(bus.res_st_wr_addr_in) < D &&
               !busy_v[bus.res_st_wr_addr_in];

  // Incoming payload picks up a same-cycle broadcast.
  always_comb begin
    wcell = bus.res_st_data_in;
    wcell.busy = 1'b1;
    if (bus.cdb_valid_in && bus.cdb_tag_in != '0) begin
      if (wcell.qj == bus.cdb_tag_in) begin
        wcell.vj = bus.cdb_data_in;
        wcell.qj = '0;
      end
      if (wcell.qk == bus.cdb_tag_in) begin
        wcell.vk = bus.cdb_data_in;
        wcell.qk = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) ent[i] <= '0;
      iss <= '0;
      iv <= 1'b0;
      iop <= '0;
      ivj <= '0;
      ivk <= '0;
      ia <= '0;
      irob <= '0;
      itag <= '0;
      err <= 1'b0;
    end else if (bus.flush_in) begin
      for (int i = 0; i < D; i++) ent[i].busy <= 1'b0;
      iss <= '0;
      iv <= 1'b0;
      err <= 1'b0;
    end else begin
      err <= bus.res_st_wr_en_in && !acc;
      if (bus.cdb_valid_in && bus.cdb_tag_in != '0) begin
        for (int i = 1; i < D; i++) begin
          if (ent[i].busy && ent[i].qj == bus.cdb_tag_in) begin
            ent[i].vj <= bus.cdb_data_in;
            ent[i].qj <= '0;
          end
          if (ent[i].busy && ent[i].qk == bus.cdb_tag_in) begin
            ent[i].vk <= bus.cdb_data_in;
            ent[i].qk <= '0;
          end
        end
      end
      if (hs) begin
        ent[itag].busy <= 1'b0;
        iss[itag] <= 1'b0;
      end
      if (load) begin
        iv <= sel_ok;
        if (sel_ok) begin
          iop <= ent[sel].op;
          ivj <= ent[sel].vj;
          ivk <= ent[sel].vk;
          ia <= ent[sel].a;
          irob <= ent[sel].rob_addr;
          itag <= sel;
          iss[sel] <= 1'b1;
        end
      end
      if (acc) ent[bus.res_st_wr_addr_in] <= wcell;
    end
  end

  assign bus.issue_valid_out = iv;
  assign bus.issue_op_out = iop;
  assign bus.issue_vj_out = ivj;
  assign bus.issue_vk_out = ivk;
  assign bus.issue_a_out = ia;
  assign bus.issue_rob_addr_out = irob;
  assign bus.issue_tag_out = itag;
  assign bus.full_out = &busy_v[D-1:1];
  assign bus.count_out = cnt;
  assign bus.wr_err_out = err;
endmodule
